// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen: turns raw set/clear request levels into mutually exclusive,
// fixed-width S/R pulses for a NOR SR latch, with a registered shadow of the
// latch state and a one-cycle conflict flag.
// Optional feature macro: SR_CMD_DEBOUNCE_EN (counter-based request debounce).

// Per-request input filter plus its one-cycle-delayed copy.
module sr_cmd_filter #(
  parameter int DB_CNT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic filt,
  output logic filt_d
);
`ifdef SR_CMD_DEBOUNCE_EN
  localparam int            CW      = $clog2(DB_CNT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CNT);

  logic [CW-1:0] cnt;

  // Saturating run-length counter of consecutive high samples; any low clears it.
  always_ff @(posedge clk) begin
    if (rst || !raw)       cnt <= '0;
    else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
  end

  assign filt = (cnt == CNT_MAX);

  // Delayed copy of the filtered level for edge detection.
  always_ff @(posedge clk) begin
    if (rst) filt_d <= 1'b0;
    else     filt_d <= filt;
  end
`else
  // Empty branch: DB_CNT only shapes the filter when debounce is built in.
  if (DB_CNT < 1) begin : g_db_cnt_unused
  end

  // Single-flop filter and its delayed copy.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt   <= 1'b0;
      filt_d <= 1'b0;
    end else begin
      filt   <= raw;
      filt_d <= filt;
    end
  end
`endif
endmodule

module sr_cmd_gen #(
  parameter int PULSE_W = 2,
  parameter int DB_CNT  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic set_req,
  input  logic clr_req,
  output logic s,
  output logic r,
  output logic busy,
  output logic state_q,
  output logic err
);
  localparam int             NUM_REQ = 2;
  localparam int             PCW     = $clog2(PULSE_W + 1);
  localparam logic [PCW-1:0] P_LAST  = PCW'(PULSE_W - 1);

  typedef enum logic [1:0] {IDLE, SET_P, CLR_P, GAP} st_t;

  typedef struct packed {
    logic clr_rise;
    logic set_rise;
  } req_t;

  logic [NUM_REQ-1:0] raw, flt, flt_d;
  req_t               req;
  st_t                st, st_nx;
  logic [PCW-1:0]     pcnt;
  logic               in_pulse, pulse_last;

  assign raw = {clr_req, set_req};

  sr_cmd_filter #(.DB_CNT(DB_CNT)) u_flt [NUM_REQ-1:0] (
    .clk    (clk),
    .rst    (rst),
    .raw    (raw),
    .filt   (flt),
    .filt_d (flt_d)
  );

  // Only rising edges of the filtered levels are commands.
  assign req = req_t'(flt & ~flt_d);

  assign in_pulse   = (st == SET_P) || (st == CLR_P);
  assign pulse_last = in_pulse && (pcnt == P_LAST);

  // Next-state: accept a single non-redundant edge in IDLE, drop everything else.
  always_comb begin
    st_nx = st;
    case (st)
      IDLE: begin
        if (req.set_rise && !req.clr_rise && !state_q)     st_nx = SET_P;
        else if (req.clr_rise && !req.set_rise && state_q) st_nx = CLR_P;
      end
      SET_P, CLR_P: if (pulse_last) st_nx = GAP;
      GAP:          st_nx = IDLE;
      default:      st_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) st <= IDLE;
    else     st <= st_nx;
  end

  // Pulse-width counter, running only inside SET_P/CLR_P.
  always_ff @(posedge clk) begin
    if (rst || !in_pulse || pulse_last) pcnt <= '0;
    else                                pcnt <= pcnt + 1'b1;
  end

  // Latch shadow flips on the edge where the drive pulse falls.
  always_ff @(posedge clk) begin
    if (rst)                             state_q <= 1'b0;
    else if (pulse_last && st == SET_P)  state_q <= 1'b1;
    else if (pulse_last && st == CLR_P)  state_q <= 1'b0;
  end

  // Conflict flag: both edges seen together while idle.
  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else     err <= (st == IDLE) && req.set_rise && req.clr_rise;
  end

  assign s    = (st == SET_P);
  assign r    = (st == CLR_P);
  assign busy = (st != IDLE);
endmodule

// File: tb/tb_sr_cmd_gen.sv
// Bench for sr_cmd_gen: random/directed request levels, a reference model
// that predicts pulse events per output, and a negedge monitor that checks
// every observed pulse against the predicted one.
module tb_sr_cmd_gen;
  localparam int PW   = 2;
  localparam int DB   = 4;
`ifdef SR_CMD_DEBOUNCE_EN
  localparam int D    = DB;
`else
  localparam int D    = 1;
`endif
  localparam int MAXE = 8000;

  logic clk = 1'b0, rst = 1'b1, set_req = 1'b0, clr_req = 1'b0;
  logic s, r, busy, state_q, err;

  sr_cmd_gen #(.PULSE_W(PW), .DB_CNT(DB)) dut (
    .clk(clk), .rst(rst), .set_req(set_req), .clr_req(clr_req),
    .s(s), .r(r), .busy(busy), .state_q(state_q), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int start;
    int width;
    bit sq;
    bit chk;
  } ev_t;

  ev_t qs[$], qr[$], qe[$], qb[$];
  int  n_cmp = 0, n_bad = 0;
  int  cyc   = 0;
  bit  rv[0:MAXE], sv[0:MAXE], cv[0:MAXE];
  int  free_e = 0;
  bit  m_sq   = 1'b0;
  int  act_e  = -100;
  bit  act_set;

  // Filtered level after edge e: the last D raw samples were all high with
  // no reset inside that window.
  function automatic bit filt(int e, bit is_clr);
    for (int j = 0; j < D; j++) begin
      int idx = e - j;
      if (idx < 1 || idx > MAXE) return 1'b0;
      if (rv[idx]) return 1'b0;
      if (!(is_clr ? cv[idx] : sv[idx])) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  // Reference model: one decision per edge, events predicted as (start, width).
  always @(posedge clk) begin
    bit rs_, rc_;
    cyc++;
    if (cyc <= MAXE) begin
      rv[cyc] = rst; sv[cyc] = set_req; cv[cyc] = clr_req;
    end
    if (rst) begin
      m_sq   = 1'b0;
      free_e = cyc + 1;
      if (act_e > 0 && cyc <= act_e + PW) begin
        if (act_set && qs.size() > 0) begin
          qs[qs.size()-1].width = imin(PW, cyc - act_e);
          qs[qs.size()-1].sq    = 1'b0;
        end else if (!act_set && qr.size() > 0) begin
          qr[qr.size()-1].width = imin(PW, cyc - act_e);
        end
        if (qb.size() > 0) qb[qb.size()-1].width = cyc - act_e;
      end
      if (qe.size() > 0) qe[qe.size()-1].sq = 1'b0;
      act_e = -100;
    end else begin
      rs_ = filt(cyc - 1, 1'b0) && !filt(cyc - 2, 1'b0);
      rc_ = filt(cyc - 1, 1'b1) && !filt(cyc - 2, 1'b1);
      if (cyc >= free_e) begin
        if (rs_ && rc_) begin
          qe.push_back('{cyc, 1, m_sq, 1'b1});
        end else if ((rs_ && !m_sq) || (rc_ && m_sq)) begin
          act_set = rs_;
          if (rs_) qs.push_back('{cyc, PW, 1'b1, 1'b1});
          else     qr.push_back('{cyc, PW, 1'b0, 1'b1});
          qb.push_back('{cyc, PW + 1, 1'b0, 1'b0});
          m_sq   = rs_;
          free_e = cyc + PW + 2;
          act_e  = cyc;
        end
      end
    end
  end

  string nm[4] = '{"s", "r", "err", "busy"};
  bit    pv[4];
  int    pst[4], plen[4];

  task automatic check_ev(int id, int st_, int len_);
    ev_t ev;
    bit  have = 1'b0;
    case (id)
      0: if (qs.size() > 0) begin ev = qs.pop_front(); have = 1'b1; end
      1: if (qr.size() > 0) begin ev = qr.pop_front(); have = 1'b1; end
      2: if (qe.size() > 0) begin ev = qe.pop_front(); have = 1'b1; end
      default: if (qb.size() > 0) begin ev = qb.pop_front(); have = 1'b1; end
    endcase
    n_cmp++;
    if (!have) begin
      n_bad++;
      $display("FAIL %s_pulse: got start=%0d width=%0d, expected no pulse", nm[id], st_, len_);
    end else if (ev.start != st_ || ev.width != len_ || (ev.chk && state_q != ev.sq)) begin
      n_bad++;
      $display("FAIL %s_pulse: got start=%0d width=%0d state_q=%0b, expected start=%0d width=%0d state_q=%0b",
               nm[id], st_, len_, state_q, ev.start, ev.width, ev.sq);
    end
  endtask

  // Monitor: measure each output pulse and retire it against the model.
  always @(negedge clk) begin
    logic [3:0] v;
    v = {busy, err, r, s};
    n_cmp++;
    if (s && r) begin
      n_bad++;
      $display("FAIL s_r_exclusive: got s=1 r=1 at edge %0d, expected not both", cyc);
    end
    for (int id = 0; id < 4; id++) begin
      if (v[id] && !pv[id]) begin
        pst[id] = cyc; plen[id] = 1;
      end else if (v[id]) begin
        plen[id]++;
      end else if (pv[id]) begin
        check_ev(id, pst[id], plen[id]);
      end
      pv[id] = v[id];
    end
  end

  task automatic cmp(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(bit st, bit cl, bit rs, int n);
    set_req = st; clr_req = cl; rst = rs;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    step(0, 0, 1, 3);
    cmp("reset_s", s, 0);
    cmp("reset_r", r, 0);
    cmp("reset_busy", busy, 0);
    cmp("reset_state_q", state_q, 0);
    cmp("reset_err", err, 0);
    step(0, 0, 0, 3);
    // basic set, held
    step(1, 0, 0, 8);
    step(0, 0, 0, 4);
    // clear, then redundant clear
    step(0, 1, 0, D);
    step(0, 0, 0, 8);
    step(0, 1, 0, D);
    step(0, 0, 0, 8);
    // conflict from idle
    step(1, 1, 0, D);
    step(0, 0, 0, 6);
    // clear raised while the set pulse is in flight
    step(1, 0, 0, D + 1);
    step(1, 1, 0, 8);
    step(0, 0, 0, 6);
    step(0, 1, 0, D);
    step(0, 0, 0, 8);
`ifdef SR_CMD_DEBOUNCE_EN
    // short burst rejected, full-length burst accepted
    step(1, 0, 0, 3);
    step(0, 0, 0, 1);
    step(1, 0, 0, 4);
    step(0, 0, 0, 8);
    step(0, 1, 0, D);
    step(0, 0, 0, 8);
`endif
    // reset during the second s cycle, request held across it
    step(1, 0, 0, D + 2);
    step(1, 0, 1, 1);
    step(1, 0, 0, 8);
    step(0, 0, 0, 6);
    // random levels with occasional resets
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 29) == 0), $urandom_range(1, 6));
    step(0, 0, 0, 20);
    cmp("pending_s", qs.size(), 0);
    cmp("pending_r", qr.size(), 0);
    cmp("pending_err", qe.size(), 0);
    cmp("pending_busy", qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
